// File: rtl/lfsr_shuffle_engine.sv
// In-place LFSR-driven Fisher-Yates shuffle (and exact inverse) of the first len
// words of a single-port regfile whose reads have one cycle of latency.
module lfsr_shuffle_engine #(
   parameter int                DATA_W    = 8,
   parameter int                ADDR_W    = 4,
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_mode,
   input  logic [ADDR_W:0]   i_len,
   input  logic [LFSR_W-1:0] i_seed,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_rd_en,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_mem_wr_en,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_busy,
   output logic              o_done
);

   // state  | meaning
   // IDLE   | wait for i_start
   // GEN    | draw LFSR candidates until i <= c < len
   // LOAD   | unscramble pass 2: recall j for index i
   // RD_I   | read mem[i]
   // RD_J   | read mem[j], hold old mem[i]
   // WR_I   | mem[i] <= old mem[j]
   // WR_J   | mem[j] <= old mem[i]
   // NEXT   | step i, loop or finish
   // FIN    | done pulse
   typedef enum logic [3:0] {
      S_IDLE, S_GEN, S_LOAD, S_RD_I, S_RD_J, S_WR_I, S_WR_J, S_NEXT, S_FIN
   } state_t;

   localparam int                DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LEN_TWO = (ADDR_W+1)'(2);
   localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

   state_t              r_state;
   logic                r_mode;
   logic [ADDR_W:0]     r_len;
   logic [LFSR_W-1:0]   r_lfsr;
   logic [ADDR_W-1:0]   r_i;
   logic [ADDR_W-1:0]   r_j;
   logic [DATA_W-1:0]   r_tmp;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_rd_en;
   logic                r_wr_en;
   logic                r_busy;
   logic                r_done;
   logic [ADDR_W-1:0]   r_jbuf [DEPTH-1];

   logic [ADDR_W:0]     w_len_clamp;
   logic [LFSR_W-1:0]   w_lfsr_next;
   logic [ADDR_W-1:0]   w_cand;
   logic                w_accept;
   logic                w_i_at_last;
   logic [ADDR_W-1:0]   w_jb;

   assign w_len_clamp = (i_len > LEN_MAX) ? LEN_MAX : i_len;
   assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
   assign w_cand      = r_lfsr[ADDR_W-1:0];
   assign w_accept    = (w_cand >= r_i) && ({1'b0, w_cand} < r_len);
   assign w_i_at_last = ({1'b0, r_i} + LEN_TWO) >= r_len;
   assign w_jb        = r_jbuf[r_i];

   assign o_mem_addr  = r_addr;
   assign o_mem_rd_en = r_rd_en;
   assign o_mem_wr_en = r_wr_en;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   // WR_I forwards the word fetched by RD_J straight from the regfile port.
   assign o_mem_wdata = !r_wr_en ? '0 : (r_state == S_WR_I) ? i_mem_rdata : r_tmp;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_mode  <= 1'b0;
         r_len   <= '0;
         r_lfsr  <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_tmp   <= '0;
         r_addr  <= '0;
         r_rd_en <= 1'b0;
         r_wr_en <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         for (int k = 0; k < DEPTH-1; k++) r_jbuf[k] <= '0;
      end else begin
         r_rd_en <= 1'b0;
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_mode <= i_mode;
                  r_len  <= w_len_clamp;
                  r_lfsr <= (i_seed == '0) ? LFSR_W'(1) : i_seed;
                  r_i    <= '0;
                  if (w_len_clamp < LEN_TWO) begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_GEN;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_GEN: begin
               r_lfsr <= w_lfsr_next;
               if (w_accept) begin
                  r_j        <= w_cand;
                  r_jbuf[r_i] <= w_cand;
                  if (r_mode) begin
                     if (w_i_at_last) r_state <= S_LOAD;
                     else             r_i     <= r_i + ONE_A;
                  end else if (w_cand == r_i) begin
                     r_state <= S_NEXT;
                  end else begin
                     r_state <= S_RD_I;
                     r_addr  <= r_i;
                     r_rd_en <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               r_j <= w_jb;
               if (w_jb == r_i) begin
                  r_state <= S_NEXT;
               end else begin
                  r_state <= S_RD_I;
                  r_addr  <= r_i;
                  r_rd_en <= 1'b1;
               end
            end
            S_RD_I: begin
               r_state <= S_RD_J;
               r_addr  <= r_j;
               r_rd_en <= 1'b1;
            end
            S_RD_J: begin
               r_state <= S_WR_I;
               r_tmp   <= i_mem_rdata;
               r_addr  <= r_i;
               r_wr_en <= 1'b1;
            end
            S_WR_I: begin
               r_state <= S_WR_J;
               r_addr  <= r_j;
               r_wr_en <= 1'b1;
            end
            S_WR_J: r_state <= S_NEXT;
            S_NEXT: begin
               if (r_mode) begin
                  if (r_i == '0) begin
                     r_state <= S_FIN;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_i     <= r_i - ONE_A;
                     r_state <= S_LOAD;
                  end
               end else begin
                  r_i <= r_i + ONE_A;
                  if (w_i_at_last) begin
                     r_state <= S_FIN;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_GEN;
                  end
               end
            end
            S_FIN:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_shuffle_engine.sv
// Bench for lfsr_shuffle_engine: regfile model, reference shuffle model and a
// write-trace scoreboard checked by per-scenario tasks.
module tb_lfsr_shuffle_engine;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int LFSR_W = 16;
   localparam int DEPTH  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              mode;
   logic [ADDR_W:0]   len;
   logic [LFSR_W-1:0] seed;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_wr_en;
   logic [DATA_W-1:0] mem_wdata;
   logic              busy;
   logic              done;

   always #5 clk = ~clk;

   lfsr_shuffle_engine #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LFSR_W(LFSR_W), .LFSR_TAPS(16'hB400)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_len(len),
      .i_seed(seed), .o_mem_addr(mem_addr), .o_mem_rd_en(mem_rd_en),
      .i_mem_rdata(mem_rdata), .o_mem_wr_en(mem_wr_en), .o_mem_wdata(mem_wdata),
      .o_busy(busy), .o_done(done)
   );

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  written;
   logic              preload;

   always @(posedge clk) begin
      if (preload) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= DATA_W'(k);
         written <= '0;
      end else begin
         if (mem_rd_en) mem_rdata <= mem[mem_addr];
         if (mem_wr_en) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
         end
      end
   end

   int checks = 0;
   int failures = 0;
   logic [11:0] exp_q [$];
   logic [11:0] obs_q [$];
   logic [DATA_W-1:0] ref_mem [DEPTH];
   int done_cnt, rd_cnt, wr_cnt;
   bit overlap, busy_seen, done_busy, busy_first;

   task automatic model_swap(input int i, input int j);
      logic [DATA_W-1:0] t;
      if (i != j) begin
         exp_q.push_back({4'(i), ref_mem[j]});
         exp_q.push_back({4'(j), ref_mem[i]});
         t = ref_mem[i]; ref_mem[i] = ref_mem[j]; ref_mem[j] = t;
      end
   endtask

   task automatic model_op(input bit m, input int n, input logic [15:0] sd);
      logic [15:0] l;
      int js [DEPTH];
      int c;
      l = sd;
      if (n < 2) return;
      for (int i = 0; i <= n-2; i++) begin
         forever begin
            c = int'(l[3:0]);
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
            if (c >= i && c < n) break;
         end
         js[i] = c;
      end
      if (!m) for (int i = 0; i <= n-2; i++) model_swap(i, js[i]);
      else    for (int i = n-2; i >= 0; i--) model_swap(i, js[i]);
   endtask

   task automatic clear_stats();
      done_cnt = 0; rd_cnt = 0; wr_cnt = 0;
      overlap = 0; busy_seen = 0; done_busy = 0; busy_first = 0;
   endtask

   task automatic sample_cycle();
      if (mem_wr_en) begin obs_q.push_back({mem_addr, mem_wdata}); wr_cnt++; end
      if (mem_rd_en) rd_cnt++;
      if (mem_rd_en && mem_wr_en) overlap = 1;
      if (done) done_cnt++;
      if (busy) busy_seen = 1;
      if (done && busy) done_busy = 1;
   endtask

   task automatic do_preload();
      @(negedge clk); preload = 1'b1;
      @(negedge clk); preload = 1'b0;
      for (int k = 0; k < DEPTH; k++) ref_mem[k] = DATA_W'(k);
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic kick(input bit m, input logic [ADDR_W:0] l, input logic [15:0] s);
      @(negedge clk);
      mode = m; len = l; seed = s; start = 1'b1;
      @(negedge clk);
      sample_cycle();
      busy_first = busy;
      start = 1'b0; mode = ~m; len = 5'($urandom); seed = 16'($urandom);
   endtask

   task automatic run_until_done(input int max_cyc, output bit ok);
      int base;
      base = done_cnt;
      ok = 0;
      for (int k = 0; k < max_cyc; k++) begin
         @(negedge clk); sample_cycle();
         if (done_cnt > base) begin ok = 1; break; end
      end
      repeat (3) begin @(negedge clk); sample_cycle(); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", mem_rd_en); end
      checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", mem_wr_en); end
      checks++; if (mem_addr !== '0)    begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
      checks++; if (mem_wdata !== '0)   begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
      rst = 1'b0;
   endtask

   task automatic test_len1();
      for (int n = 0; n < 2; n++) begin
         clear_stats();
         kick(1'b0, 5'(n), 16'h1234);
         checks++; if (done_cnt != 1) begin failures++; $display("FAIL short_done_next_cycle len=%0d got=%0d exp=1", n, done_cnt); end
         repeat (6) begin @(negedge clk); sample_cycle(); end
         checks++; if (done_cnt != 1) begin failures++; $display("FAIL short_single_done len=%0d got=%0d exp=1", n, done_cnt); end
         checks++; if (rd_cnt + wr_cnt != 0) begin failures++; $display("FAIL short_no_mem len=%0d got=%0d exp=0", n, rd_cnt + wr_cnt); end
         checks++; if (busy_seen) begin failures++; $display("FAIL short_busy_never len=%0d got=1 exp=0", n); end
      end
   endtask

   task automatic test_scramble16();
      bit ok;
      logic [11:0] e, o;
      logic [DEPTH-1:0] seen;
      do_preload();
      model_op(1'b0, 16, 16'hACE1);
      clear_stats();
      kick(1'b0, 5'd16, 16'hACE1);
      checks++; if (busy_first !== 1'b1) begin failures++; $display("FAIL scr16_busy_rise got=%b exp=1", busy_first); end
      run_until_done(3000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL scr16_done_timeout got=none exp=done"); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL scr16_done_count got=%0d exp=1", done_cnt); end
      checks++; if (done_busy || overlap) begin failures++; $display("FAIL scr16_strobes got=done_busy:%b overlap:%b exp=0:0", done_busy, overlap); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL scr16_trace_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL scr16_write got=%h exp=%h", o, e); end
      end
      seen = '0;
      for (int k = 0; k < DEPTH; k++) begin
         checks++; if (mem[k] !== ref_mem[k]) begin failures++; $display("FAIL scr16_mem[%0d] got=%h exp=%h", k, mem[k], ref_mem[k]); end
         seen[mem[k][3:0]] = 1'b1;
      end
      checks++; if (seen !== 16'hFFFF) begin failures++; $display("FAIL scr16_permutation got=%h exp=ffff", seen); end
   endtask

   task automatic test_roundtrip();
      bit ok1, ok2;
      logic [11:0] e, o;
      int lens [2] = '{16, 5};
      foreach (lens[t]) begin
         do_preload();
         model_op(1'b0, lens[t], 16'hACE1);
         model_op(1'b1, lens[t], 16'hACE1);
         clear_stats();
         kick(1'b0, 5'(lens[t]), 16'hACE1);
         run_until_done(3000, ok1);
         kick(1'b1, 5'(lens[t]), 16'hACE1);
         run_until_done(3000, ok2);
         checks++; if (!(ok1 && ok2) || done_cnt != 2) begin failures++; $display("FAIL rt%0d_done got=%0d exp=2", lens[t], done_cnt); end
         checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rt%0d_trace_len got=%0d exp=%0d", lens[t], obs_q.size(), exp_q.size()); end
         while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL rt%0d_write got=%h exp=%h", lens[t], o, e); end
         end
         for (int k = 0; k < DEPTH; k++) begin
            checks++; if (mem[k] !== DATA_W'(k)) begin failures++; $display("FAIL rt%0d_restore[%0d] got=%h exp=%h", lens[t], k, mem[k], k); end
         end
      end
      checks++; if (written[15:5] !== '0) begin failures++; $display("FAIL rt5_untouched got=%h exp=0", written[15:5]); end
   endtask

   task automatic test_seed_len();
      bit ok;
      logic [11:0] e, o;
      logic [11:0] tr [2][$];
      logic [15:0] seeds [2] = '{16'h0000, 16'h0001};
      foreach (seeds[t]) begin
         do_preload();
         model_op(1'b0, 8, 16'h0001);
         clear_stats();
         kick(1'b0, 5'd8, seeds[t]);
         run_until_done(3000, ok);
         checks++; if (!ok) begin failures++; $display("FAIL seed%0d_done_timeout got=none exp=done", t); end
         tr[t] = obs_q;
         checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL seed%0d_trace_len got=%0d exp=%0d", t, obs_q.size(), exp_q.size()); end
         while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL seed%0d_write got=%h exp=%h", t, o, e); end
         end
      end
      checks++; if (tr[0].size() != tr[1].size()) begin failures++; $display("FAIL seed0_vs_1_len got=%0d exp=%0d", tr[0].size(), tr[1].size()); end
      for (int k = 0; k < tr[0].size() && k < tr[1].size(); k++) begin
         checks++; if (tr[0][k] !== tr[1][k]) begin failures++; $display("FAIL seed0_vs_1[%0d] got=%h exp=%h", k, tr[0][k], tr[1][k]); end
      end
      do_preload();
      model_op(1'b0, 16, 16'h1357);
      clear_stats();
      kick(1'b0, 5'd20, 16'h1357);
      run_until_done(3000, ok);
      checks++; if (!ok || done_cnt != 1) begin failures++; $display("FAIL len20_done got=%0d exp=1", done_cnt); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL len20_trace_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL len20_write got=%h exp=%h", o, e); end
      end
      for (int k = 0; k < DEPTH; k++) begin
         checks++; if (mem[k] !== ref_mem[k]) begin failures++; $display("FAIL len20_mem[%0d] got=%h exp=%h", k, mem[k], ref_mem[k]); end
      end
   endtask

   task automatic test_busy_ignore();
      bit ok;
      logic [11:0] e, o;
      do_preload();
      model_op(1'b0, 16, 16'h5A5A);
      clear_stats();
      kick(1'b0, 5'd16, 16'h5A5A);
      repeat (10) begin @(negedge clk); sample_cycle(); end
      start = 1'b1; mode = 1'b1; len = 5'd3; seed = 16'h1111;
      repeat (3) begin @(negedge clk); sample_cycle(); end
      start = 1'b0;
      run_until_done(3000, ok);
      checks++; if (!ok || done_cnt != 1) begin failures++; $display("FAIL busy_ign_done got=%0d exp=1", done_cnt); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL busy_ign_trace_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL busy_ign_write got=%h exp=%h", o, e); end
      end
      for (int k = 0; k < DEPTH; k++) begin
         checks++; if (mem[k] !== ref_mem[k]) begin failures++; $display("FAIL busy_ign_mem[%0d] got=%h exp=%h", k, mem[k], ref_mem[k]); end
      end
   endtask

   task automatic test_rst_mid();
      bit ok, found;
      logic [11:0] e, o;
      do_preload();
      model_op(1'b0, 16, 16'hACE1);
      clear_stats();
      kick(1'b0, 5'd16, 16'hACE1);
      found = 0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk); sample_cycle();
         if (mem_wr_en) begin found = 1; break; end
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (!found) begin failures++; $display("FAIL rst_mid_no_wr_i got=none exp=write"); end
      checks++; if ({busy, done, mem_rd_en, mem_wr_en} !== 4'b0000) begin failures++; $display("FAIL rst_mid_strobes got=%b exp=0000", {busy, done, mem_rd_en, mem_wr_en}); end
      checks++; if ({mem_addr, mem_wdata} !== 12'h000) begin failures++; $display("FAIL rst_mid_bus got=%h exp=000", {mem_addr, mem_wdata}); end
      @(negedge clk); rst = 1'b0;
      checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL rst_mid_writes_before got=%0d exp=1", obs_q.size()); end
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q[0]; o = obs_q[0]; checks++;
         if (o !== e) begin failures++; $display("FAIL rst_mid_wr_i got=%h exp=%h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
      clear_stats();
      repeat (30) begin @(negedge clk); sample_cycle(); end
      checks++; if (wr_cnt + rd_cnt != 0 || busy_seen) begin failures++; $display("FAIL rst_mid_quiet got=wr:%0d rd:%0d busy:%b exp=0:0:0", wr_cnt, rd_cnt, busy_seen); end
      do_preload();
      model_op(1'b0, 16, 16'h0BAD);
      clear_stats();
      kick(1'b0, 5'd16, 16'h0BAD);
      run_until_done(3000, ok);
      checks++; if (!ok || done_cnt != 1) begin failures++; $display("FAIL rst_after_done got=%0d exp=1", done_cnt); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rst_after_trace_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL rst_after_write got=%h exp=%h", o, e); end
      end
      for (int k = 0; k < DEPTH; k++) begin
         checks++; if (mem[k] !== ref_mem[k]) begin failures++; $display("FAIL rst_after_mem[%0d] got=%h exp=%h", k, mem[k], ref_mem[k]); end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; len = '0; seed = '0; preload = 1'b0;
      clear_stats();
      test_reset();
      test_len1();
      test_scramble16();
      test_roundtrip();
      test_seed_len();
      test_busy_ignore();
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
